// File: rtl/stream_zero_counter.sv
// Packet-level leading/trailing zero counter for multi-word operands.
// Words stream in over valid/ready; the count is returned on a valid/ready result port.
module stream_zero_counter #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WORDS  = 8,
    localparam int CNT_W     = $clog2(DATA_WIDTH * MAX_WORDS) + 1,
    localparam int WC_W      = $clog2(MAX_WORDS + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  din_valid,
    input  logic                  din_last,
    input  logic                  mode,
    output logic                  din_ready,
    output logic [CNT_W-1:0]      dout,
    output logic                  dout_err,
    output logic                  dout_valid,
    input  logic                  dout_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [WC_W-1:0] WC_MAX = WC_W'(MAX_WORDS);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              found_q, found_d;
    logic [WC_W-1:0]   wcnt_q, wcnt_d;
    logic              err_q, err_d;
    logic              mode_q, mode_d;

    logic              accept;
    logic              eff_mode;
    logic [CNT_W-1:0]  tz;
    logic [CNT_W-1:0]  lz;
    logic [CNT_W-1:0]  z;

    // Trailing zeros of the incoming word; the lowest set bit wins.
    always_comb begin
        tz = CNT_W'(DATA_WIDTH);
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            if (din[i]) tz = CNT_W'(i);
        end
    end

    // Leading zeros of the incoming word; the highest set bit wins.
    always_comb begin
        lz = CNT_W'(DATA_WIDTH);
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (din[i]) lz = CNT_W'(DATA_WIDTH - 1 - i);
        end
    end

    assign din_ready  = !reset && (state_q != DONE);
    assign accept     = din_valid && din_ready;
    assign eff_mode   = (state_q == IDLE) ? mode : mode_q;
    assign z          = eff_mode ? lz : tz;

    assign dout       = count_q;
    assign dout_err   = err_q;
    assign dout_valid = (state_q == DONE);

    // Next-state and accumulation logic.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        found_d = found_q;
        wcnt_d  = wcnt_q;
        err_d   = err_q;
        mode_d  = mode_q;

        if (accept) begin
            if (state_q == IDLE) mode_d = mode;
            if (!found_q && (wcnt_q < WC_MAX)) begin
                count_d = count_q + z;
                found_d = (din != '0);
            end
            if (wcnt_q == WC_MAX) err_d = 1'b1;
            else                  wcnt_d = wcnt_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (accept) state_d = din_last ? DONE : ACCUM;
            end
            ACCUM: begin
                if (accept && din_last) state_d = DONE;
            end
            DONE: begin
                if (dout_ready) begin
                    state_d = IDLE;
                    count_d = '0;
                    found_d = 1'b0;
                    wcnt_d  = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            found_q <= 1'b0;
            wcnt_q  <= '0;
            err_q   <= 1'b0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            found_q <= found_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
            mode_q  <= mode_d;
        end
    end

endmodule
